bounce_gen: RTL and testbench
=============================

BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter N_BOUNCE, default 3: glitch pairs emitted before settling; legal range 0..7.
REQ-002 Parameter W, default 4: interval counter width; legal range 2..8.
REQ-003 Parameter SEED, default 8'hA5: LFSR reset value.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to transition the emulated contact; sampled on the rising edge of clk.
REQ-007 level  input  1  target settled level; sampled together with start.
REQ-008 bounce_out  output  1  emulated bouncing switch contact, registered.
REQ-009 busy  output  1  high while a transition is in progress, registered.
REQ-010 done  output  1  one-cycle pulse marking the end of a transition, registered.

Function
REQ-011 The block SHALL implement an FSM with three states: IDLE, GLITCH and SETTLE.
REQ-012 The block SHALL contain an 8-bit Fibonacci LFSR with polynomial x^8+x^6+x^5+x^4+1 that advances every clock cycle in all states.
REQ-013 If SEED is 8'h00, the LFSR SHALL use 8'h01 instead.
REQ-014 Interval draw: I = lfsr[W-1:0], with bit 0 forced to 1, so 1 <= I <= 2^W-1.
REQ-015 In IDLE, start=1 with level != bounce_out SHALL, on the same edge:
- toggle bounce_out
- load the interval counter with I
- set the toggle count to 1
- set busy=1
- move to GLITCH.
REQ-016 In IDLE, start=1 with level == bounce_out SHALL:
- produce done=1 for exactly one cycle starting at the next edge
- leave bounce_out unchanged and busy=0
- remain in IDLE.
REQ-017 In GLITCH, the interval counter SHALL decrement each cycle; on the edge where it would reach 0:
- bounce_out toggles
- the toggle count increments
- a new I is loaded.
REQ-018 Consecutive toggles SHALL be separated by exactly I clock edges, where I is the value loaded at the previous toggle.
REQ-019 Each transition SHALL produce exactly 2*N_BOUNCE+1 toggles of bounce_out, so the final value equals the sampled level.
REQ-020 The sampled level SHALL be held in a register; changes on level or start outside IDLE SHALL be ignored.
REQ-021 On the final toggle, the FSM SHALL enter SETTLE and load the settle counter with 2^W.
REQ-022 In SETTLE, bounce_out SHALL remain constant.
REQ-023 Exactly 2^W edges after the final toggle:
- busy SHALL fall
- done SHALL be 1 for one cycle
- the FSM SHALL return to IDLE.
REQ-024 start asserted on the same edge that done is asserted SHALL be ignored; the earliest new start is accepted one cycle after done.
REQ-025 With N_BOUNCE=0, a transition SHALL consist of a single toggle followed directly by SETTLE.
REQ-026 The toggle counter SHALL be wide enough for 2*N_BOUNCE+1 and SHALL NOT wrap.

Reset
REQ-027 While rst=1, the block SHALL hold, asynchronously:
- bounce_out=0, busy=0, done=0
- FSM=IDLE
- all counters 0
- LFSR=SEED (or 8'h01 when SEED is 0).
REQ-028 Asserting rst mid-GLITCH or mid-SETTLE SHALL abort the transition immediately, with no done pulse.
REQ-029 The first edge after rst deasserts SHALL behave as IDLE.

Verification
REQ-030 Defaults, release reset, pulse start with level=1 -> bounce_out toggles 7 times (final 1), every gap in 1..15 cycles, done pulses 16 cycles after the 7th toggle, busy high from the start edge through the edge before done.
REQ-031 After REQ-030, start with level=1 -> no toggle, done=1 one cycle later, busy stays 0.
REQ-032 Start with level=0 while busy, then level toggled randomly during GLITCH -> start and level are ignored, transition completes with the original target, and exactly 7 toggles occur.
REQ-033 rst pulsed during the 3rd glitch interval -> bounce_out=0, busy=0, done=0 immediately and no done pulse afterwards; a subsequent start with level=1 reproduces the REQ-030 gap sequence, since the LFSR restarts from SEED.
REQ-034 N_BOUNCE=0, W=2 -> a single toggle, done 4 cycles later; SEED=8'h00 -> the LFSR never locks at zero over 600 cycles.
REQ-035 Back-to-back transitions with level alternating 1,0,1 and start issued one cycle after each done -> three complete 7-toggle transitions with correct final levels and no missed done.

Source files
------------

// File: rtl/bounce_gen.sv
// Switch-contact bounce emulator: on a level change it emits 2*N_BOUNCE+1 toggles
// at LFSR-drawn intervals, then holds the level for 2^W cycles before reporting done.
module bounce_gen #(
  parameter int unsigned N_BOUNCE = 3,
  parameter int unsigned W        = 4,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic level,
  output logic bounce_out,
  output logic busy,
  output logic done
);

  localparam logic [7:0]  SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int unsigned TOG_MAX    = 2 * N_BOUNCE + 1;
  localparam int unsigned TW         = $clog2(TOG_MAX + 1);
  localparam logic [TW-1:0] TOG_PEN  = TW'(TOG_MAX - 1);
  localparam logic [W:0]  SETTLE_LEN = {1'b1, {W{1'b0}}};
  localparam logic [W:0]  CNT_ONE    = (W+1)'(1);

  typedef enum logic [1:0] {IDLE, GLITCH, SETTLE} state_t;

  state_t        state_q;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [W:0]    cnt_q, ival;
  logic [TW-1:0] tog_q;
  logic          level_q;
  logic          ack_q;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    ival   = {1'b0, lfsr_q[W-1:1], 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED_EFF;
      cnt_q      <= '0;
      tog_q      <= '0;
      level_q    <= 1'b0;
      ack_q      <= 1'b0;
      bounce_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      done   <= 1'b0;
      ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // A no-op request acknowledges one edge later; start on that edge is ignored.
          if (ack_q) begin
            done <= 1'b1;
          end else if (start) begin
            if (level != bounce_out) begin
              bounce_out <= ~bounce_out;
              level_q    <= level;
              tog_q      <= TW'(1);
              busy       <= 1'b1;
              if (TOG_MAX == 1) begin
                state_q <= SETTLE;
                cnt_q   <= SETTLE_LEN;
              end else begin
                state_q <= GLITCH;
                cnt_q   <= ival;
              end
            end else begin
              ack_q <= 1'b1;
            end
          end
        end
        GLITCH: begin
          if (cnt_q == CNT_ONE) begin
            tog_q <= tog_q + TW'(1);
            if (tog_q == TOG_PEN) begin
              bounce_out <= level_q;
              state_q    <= SETTLE;
              cnt_q      <= SETTLE_LEN;
            end else begin
              bounce_out <= ~bounce_out;
              cnt_q      <= ival;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_ONE) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            tog_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: default instance plus an N_BOUNCE=0, W=2, SEED=0 instance.
module tb_bounce_gen;

  localparam int W_TB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, level = 1'b0;
  logic bounce_out, busy, done;
  logic start2 = 1'b0, level2 = 1'b0;
  logic bounce2, busy2, done2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bounce_gen dut (
    .clk(clk), .rst(rst), .start(start), .level(level),
    .bounce_out(bounce_out), .busy(busy), .done(done)
  );

  bounce_gen #(.N_BOUNCE(0), .W(2), .SEED(8'h00)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .level(level2),
    .bounce_out(bounce2), .busy(busy2), .done(done2)
  );

  // Reference LFSR for the default instance; m_used is the value present before the last edge.
  logic [7:0] m_lfsr, m_used;
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 8'hA5;
      m_used <= 8'hA5;
    end else begin
      m_used <= m_lfsr;
      m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  int gaps[6];
  int ref_gaps[6];
  int ngap;

  typedef struct {
    logic lvl;
    logic noise;
    int   exp_tog;
  } vec_t;

  task automatic reset_and_wait();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bounce", bounce_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lfsr_seed0", dut2.lfsr_q, 8'h01);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_bounce", bounce_out, 0);
    end
  endtask

  task automatic run_row(input logic lvl, input logic noise, input int exp_tog);
    logic prev, last;
    int tog, since, exp_gap;
    bit fin;
    check("idle_busy", busy, 0);
    prev = bounce_out;
    start = 1'b1;
    level = lvl;
    @(negedge clk);
    if (!noise) start = 1'b0;
    if (exp_tog == 0) begin
      check("noop_hold", bounce_out, prev);
      check("noop_busy", busy, 0);
      check("noop_done_early", done, 0);
      start = 1'b0;
      @(negedge clk);
      check("noop_done", done, 1);
      check("noop_busy2", busy, 0);
      check("noop_hold2", bounce_out, prev);
      return;
    end
    check("start_toggle", bounce_out, !prev);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    tog = 1;
    last = bounce_out;
    since = 0;
    ngap = 0;
    exp_gap = int'(m_used[W_TB-1:0] | 4'd1);
    fin = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (noise) level = 1'($urandom_range(0, 1));
      @(negedge clk);
      since++;
      if (bounce_out != last) begin
        tog++;
        last = bounce_out;
        check("gap", since, exp_gap);
        check("gap_range", int'(since >= 1 && since <= 15), 1);
        if (ngap < 6) gaps[ngap] = since;
        ngap++;
        exp_gap = int'(m_used[W_TB-1:0] | 4'd1);
        since = 0;
      end
      if (done) begin
        check("toggles", tog, exp_tog);
        check("final_level", bounce_out, lvl);
        check("settle_len", since, 16);
        check("done_busy", busy, 0);
        if (noise) start = 1'b0;
        fin = 1;
        break;
      end else begin
        check("busy_high", busy, 1);
      end
    end
    if (!fin) begin
      start = 1'b0;
      check("done_timeout", 0, 1);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int t;
    logic last;
    int c;
    bit seen;

    vecs[0] = '{lvl: 1'b1, noise: 1'b0, exp_tog: 7};
    vecs[1] = '{lvl: 1'b1, noise: 1'b0, exp_tog: 0};
    vecs[2] = '{lvl: 1'b0, noise: 1'b1, exp_tog: 7};
    vecs[3] = '{lvl: 1'b1, noise: 1'b0, exp_tog: 7};
    vecs[4] = '{lvl: 1'b0, noise: 1'b0, exp_tog: 7};
    vecs[5] = '{lvl: 1'b1, noise: 1'b0, exp_tog: 7};

    reset_and_wait();
    for (int i = 0; i < 6; i++) begin
      run_row(vecs[i].lvl, vecs[i].noise, vecs[i].exp_tog);
      if (i == 0) ref_gaps = gaps;
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after", busy, 0);

    // Reset during the third glitch interval, then replay the first transition.
    @(negedge clk);
    reset_and_wait();
    start = 1'b1;
    level = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 1;
    last = bounce_out;
    for (int cyc = 0; cyc < 100 && t < 3; cyc++) begin
      @(negedge clk);
      if (bounce_out != last) begin
        t++;
        last = bounce_out;
      end
    end
    check("reached_third_toggle", t, 3);
    rst = 1'b1;
    #1;
    check("async_rst_bounce", bounce_out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    reset_and_wait();
    run_row(1'b1, 1'b0, 7);
    for (int i = 0; i < 6; i++) check("replay_gap", gaps[i], ref_gaps[i]);

    // Single-toggle instance.
    @(negedge clk);
    start2 = 1'b1;
    level2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("n0_toggle", bounce2, 1);
    check("n0_busy", busy2, 1);
    check("n0_done_early", done2, 0);
    c = 0;
    seen = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      c++;
      check("n0_stable", bounce2, 1);
      if (done2) begin
        seen = 1;
        break;
      end
    end
    check("n0_done_seen", int'(seen), 1);
    check("n0_settle_len", c, 4);
    check("n0_busy_fall", busy2, 0);

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      check("lfsr_nonzero", int'(dut2.lfsr_q != 8'h00), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
